// File: rtl/cmd_frame_pkg.sv
// Shared constants, state encoding and helpers for the host-side command frame serializer.
package cmd_frame_pkg;

    localparam logic [1:0] CMD_WRITE  = 2'b01;
    localparam logic [1:0] CMD_READ   = 2'b10;
    localparam logic [7:0] FRAME_TERM = 8'hFF;
    localparam logic [7:0] FILL_BYTE  = 8'h00;
    localparam logic [7:0] SUB_BYTE   = 8'hFE;
    localparam int unsigned ADDR_BYTES = 4;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StGap,
        StData,
        StTerm
    } tx_state_e;

    // Address bytes go out LSB first; the top byte only carries the bits above 24.
    function automatic logic [7:0] addr_byte(input logic [31:0] addr, input logic [1:0] idx);
        return addr[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/cmd_tx_outreg.sv
// Single-entry valid/ready output register; accepts a new byte whenever its slot is free.
module cmd_tx_outreg (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       slot_free
);

    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;

    assign slot_free = !valid_q || tx_ready;
    assign tx_data   = data_q;
    assign tx_valid  = valid_q;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (slot_free) begin
            valid_d = load_valid;
            if (load_valid) begin
                data_d = load_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/cmd_frame_tx.sv
// Command frame serializer: cmd byte, 4 address bytes, one idle gap, payload, 0xFF terminator.
// Optional CMD_TX_FF_GUARD_EN substitutes 0xFE for 0xFF write payload bytes and pulses err_ff.
module cmd_frame_tx
    import cmd_frame_pkg::*;
#(
    parameter int unsigned ADDR_W = 26,
    parameter int unsigned LEN_W  = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_type,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [7:0]        wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              err_ff
);

    tx_state_e         state_q, state_d;
    logic [1:0]        type_q, type_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [1:0]        acnt_q, acnt_d;
    logic [LEN_W-1:0]  dcnt_q, dcnt_d;
    logic              done_q, done_d;
    logic              cmd_ready_q, cmd_ready_d;

    logic        slot_free;
    logic        load_valid;
    logic [7:0]  load_data;
    logic [7:0]  pay_byte;
    logic [31:0] addr_ext;
    logic        is_write;

    assign addr_ext   = 32'(addr_q);
    assign is_write   = (type_q == CMD_WRITE);
    assign busy       = (state_q != StIdle);
    assign frame_done = done_q;
    assign cmd_ready  = cmd_ready_q;

`ifdef CMD_TX_FF_GUARD_EN
    // A raw 0xFF in the payload would end the frame early at the parser.
    assign pay_byte = (wr_data == FRAME_TERM) ? SUB_BYTE : wr_data;
    assign err_ff   = wr_ready && wr_valid && (wr_data == FRAME_TERM);
`else
    assign pay_byte = wr_data;
    assign err_ff   = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        addr_d     = addr_q;
        len_d      = len_q;
        acnt_d     = acnt_q;
        dcnt_d     = dcnt_q;
        done_d     = 1'b0;
        load_valid = 1'b0;
        load_data  = FILL_BYTE;
        wr_ready   = 1'b0;

        // Each state names the byte currently held in the output register.
        case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready_q) begin
                    type_d     = cmd_type;
                    addr_d     = cmd_addr;
                    len_d      = cmd_len;
                    acnt_d     = 2'd0;
                    dcnt_d     = '0;
                    load_valid = 1'b1;
                    load_data  = {6'b0, cmd_type};
                    state_d    = StCmd;
                end
            end
            StCmd: begin
                if (slot_free) begin
                    load_valid = 1'b1;
                    load_data  = addr_byte(addr_ext, 2'd0);
                    acnt_d     = 2'd0;
                    state_d    = StAddr;
                end
            end
            StAddr: begin
                if (slot_free) begin
                    if (acnt_q == 2'(ADDR_BYTES - 1)) begin
                        state_d = StGap;
                    end else begin
                        acnt_d     = acnt_q + 2'd1;
                        load_valid = 1'b1;
                        load_data  = addr_byte(addr_ext, acnt_q + 2'd1);
                    end
                end
            end
            // The gap cycle always has a free slot, so it feeds the first payload byte.
            StGap, StData: begin
                if (slot_free) begin
                    state_d = StData;
                    if (dcnt_q == len_q) begin
                        load_valid = 1'b1;
                        load_data  = FRAME_TERM;
                        state_d    = StTerm;
                    end else if (is_write) begin
                        wr_ready = 1'b1;
                        if (wr_valid) begin
                            load_valid = 1'b1;
                            load_data  = pay_byte;
                            dcnt_d     = dcnt_q + LEN_W'(1);
                        end
                    end else begin
                        load_valid = 1'b1;
                        load_data  = FILL_BYTE;
                        dcnt_d     = dcnt_q + LEN_W'(1);
                    end
                end
            end
            StTerm: begin
                if (slot_free) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        cmd_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            type_q      <= 2'b00;
            addr_q      <= '0;
            len_q       <= '0;
            acnt_q      <= 2'd0;
            dcnt_q      <= '0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            acnt_q      <= acnt_d;
            dcnt_q      <= dcnt_d;
            done_q      <= done_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    cmd_tx_outreg u_outreg (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_data  (load_data),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .slot_free  (slot_free)
    );

endmodule

// File: tb/tb_cmd_frame_tx.sv
// Self-checking bench for cmd_frame_tx: directed and random frames against a byte-list model.
module tb_cmd_frame_tx;

    typedef logic [7:0] bq_t[$];

`ifdef CMD_TX_FF_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [25:0] cmd_addr;
    logic [6:0]  cmd_len;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        frame_done;
    logic        err_ff;

    cmd_frame_tx #(.ADDR_W(26), .LEN_W(7)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_type   (cmd_type),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .err_ff     (err_ff)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bq_t  exp_q;
    bq_t  tx_q;
    bq_t  wr_q;
    int   tx_cyc[$];
    bit   vld_hist[int];
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   err_cnt = 0;
    bit   wr_ready_seen = 0;
    bit   wr_fire = 0;
    int   stall_mode = 0;
    bit   gap_en = 0;
    bit   prev_stall = 0;
    logic [7:0] prev_data = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial forever begin
        bit exp_err;
        @(negedge clk);
        wr_fire = 1'b0;
        if (reset_n) begin
            vld_hist[cyc] = tx_valid;
            if (prev_stall) begin
                check("hold_valid", 32'(tx_valid), 32'd1);
                check("hold_data", 32'(tx_data), 32'(prev_data));
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (tx_valid && tx_ready) begin
                tx_q.push_back(tx_data);
                tx_cyc.push_back(cyc);
            end
            if (wr_ready) wr_ready_seen = 1'b1;
            wr_fire = wr_valid && wr_ready;
            exp_err = GUARD && wr_fire && (wr_data == 8'hFF);
            check("err_ff", 32'(err_ff), 32'(exp_err));
            if (err_ff) err_cnt++;
            if (busy) check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_cmd_ready", 32'(cmd_ready), 32'd1);
                check("done_busy", 32'(busy), 32'd0);
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Payload source and sink back-pressure.
    initial begin
        int held = 0;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (wr_fire && wr_q.size() > 0) void'(wr_q.pop_front());
            if (wr_q.size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
                wr_valid = 1'b1;
                wr_data  = wr_q[0];
            end else begin
                wr_valid = 1'b0;
                wr_data  = 8'($urandom);
            end
            if (stall_mode == 1) begin
                tx_ready = ($urandom_range(0, 9) > 2);
            end else if (stall_mode == 2) begin
                if (tx_valid && tx_q.size() >= 1 && tx_q.size() <= 4 && held < 3) begin
                    tx_ready = 1'b0;
                    held++;
                end else begin
                    tx_ready = 1'b1;
                    held = 0;
                end
            end else begin
                tx_ready = 1'b1;
            end
        end
    end

    // Reference frame: command, address LSB first, payload (or zero fill), terminator.
    function automatic void model_frame(input logic [1:0] t, input logic [25:0] a, input int len,
                                        input bq_t pay);
        int aa = int'(a);
        exp_q.push_back({6'b0, t});
        for (int i = 0; i < 4; i++) exp_q.push_back(8'((aa >> (8 * i)) & 255));
        for (int i = 0; i < len; i++) begin
            if (t == 2'b01) exp_q.push_back((GUARD && pay[i] == 8'hFF) ? 8'hFE : pay[i]);
            else exp_q.push_back(8'h00);
        end
        exp_q.push_back(8'hFF);
    endfunction

    task automatic begin_frame();
        tx_q.delete();
        tx_cyc.delete();
        exp_q.delete();
        wr_ready_seen = 1'b0;
    endtask

    task automatic make_payload(input logic [1:0] t, input int len, input bit force_ff,
                                output bq_t pay);
        pay.delete();
        if (t == 2'b01) begin
            for (int i = 0; i < len; i++) begin
                logic [7:0] b = 8'($urandom);
                if (force_ff && i % 2 == 0) b = 8'hFF;
                pay.push_back(b);
                wr_q.push_back(b);
            end
        end
    endtask

    task automatic send_cmd(input logic [1:0] t, input logic [25:0] a, input int len,
                            output int acc);
        cmd_type  = t;
        cmd_addr  = a;
        cmd_len   = 7'(len);
        cmd_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("cmd_accepted", 32'(acc >= 0), 32'd1);
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("frame_done_seen", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic check_stream();
        check("frame_bytes", 32'(tx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
            check($sformatf("byte%0d", i), 32'(tx_q[i]), 32'(exp_q[i]));
    endtask

    task automatic check_timing(input int base, input int len, input int acc, input bit exact,
                                input bit nogap);
        int g;
        if (tx_cyc.size() < base + 6 + len) return;
        g = tx_cyc[base + 4] + 1;
        check("gap_idle", 32'(vld_hist[g]), 32'd0);
        if (nogap) check("gap_once", 32'(vld_hist[g + 1]), 32'd1);
        if (exact) begin
            for (int i = 0; i <= 5 + len; i++)
                check($sformatf("cyc%0d", i), 32'(tx_cyc[base + i]),
                      32'((i < 5) ? acc + 1 + i : acc + 2 + i));
        end
    endtask

    task automatic run_frame(input logic [1:0] t, input logic [25:0] a, input int len,
                             input bit force_ff, input bit exact);
        bq_t pay;
        int  acc;
        int  d0 = done_cnt;
        begin_frame();
        make_payload(t, len, force_ff, pay);
        model_frame(t, a, len, pay);
        send_cmd(t, a, len, acc);
        wait_done(d0 + 1);
        check_stream();
        check_timing(0, len, acc, exact, !gap_en);
        if (exact) check("done_cycle", 32'(done_cyc), 32'(acc + 8 + len));
        if (t != 2'b01 || len == 0) check("no_wr_ready", 32'(wr_ready_seen), 32'd0);
    endtask

    initial begin
        bq_t pay_a;
        bq_t pay_b;
        int  acc_a;
        int  acc_b;
        int  d0;
        int  len_a;
        int  n;

        cmd_valid = 1'b0;
        cmd_type  = 2'b00;
        cmd_addr  = '0;
        cmd_len   = '0;
        reset_n   = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_err_ff", 32'(err_ff), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Directed write: 01 EF CD AB 02, gap, 11 22 33 FF.
        begin_frame();
        pay_a = '{8'h11, 8'h22, 8'h33};
        foreach (pay_a[i]) wr_q.push_back(pay_a[i]);
        model_frame(2'b01, 26'h2ABCDEF, 3, pay_a);
        d0 = done_cnt;
        send_cmd(2'b01, 26'h2ABCDEF, 3, acc_a);
        wait_done(d0 + 1);
        check_stream();
        check_timing(0, 3, acc_a, 1'b1, 1'b1);
        check("wr_done_n11", 32'(done_cyc), 32'(acc_a + 11));

        // Read with zero length.
        run_frame(2'b10, 26'h0000010, 0, 1'b0, 1'b1);

        // Address-byte stalls.
        stall_mode = 2;
        run_frame(2'b01, 26'($urandom), 2, 1'b0, 1'b0);
        stall_mode = 0;

        // Write with payload gaps plus a second descriptor held off while busy.
        gap_en = 1'b1;
        begin_frame();
        len_a = 5;
        make_payload(2'b01, len_a, 1'b0, pay_a);
        model_frame(2'b01, 26'h1234567, len_a, pay_a);
        model_frame(2'b10, 26'h3FFFFFF, 3, pay_b);
        d0 = done_cnt;
        send_cmd(2'b01, 26'h1234567, len_a, acc_a);
        send_cmd(2'b10, 26'h3FFFFFF, 3, acc_b);
        check("b_after_a_done", 32'(done_cnt), 32'(d0 + 1));
        wait_done(d0 + 2);
        gap_en = 1'b0;
        check_stream();
        check_timing(0, len_a, acc_a, 1'b0, 1'b0);
        check_timing(6 + len_a, 3, acc_b, 1'b1, 1'b1);

        // Payload 0xFF handling.
        n = err_cnt;
        run_frame(2'b01, 26'h0ABCDEF, 3, 1'b1, 1'b1);
        check("err_ff_pulses", 32'(err_cnt - n), GUARD ? 32'd2 : 32'd0);

        // Random frames under random back-pressure and payload gaps.
        stall_mode = 1;
        for (int k = 0; k < 10; k++) begin
            gap_en = 1'($urandom_range(0, 1));
            run_frame(2'($urandom_range(0, 3)), 26'($urandom), int'($urandom_range(0, 8)),
                      1'($urandom_range(0, 1)), 1'b0);
        end
        gap_en = 1'b0;
        stall_mode = 0;

        // Reset during payload byte 2.
        begin_frame();
        make_payload(2'b01, 4, 1'b0, pay_a);
        send_cmd(2'b01, 26'h0055AA1, 4, acc_a);
        n = 0;
        while (tx_q.size() < 6 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reached_payload", 32'(tx_q.size() >= 6), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_tx_valid", 32'(tx_valid), 32'd0);
        check("midrst_tx_data", 32'(tx_data), 32'h00);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("midrst_frame_done", 32'(frame_done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        wr_q.delete();
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame(2'b01, 26'h1F0F0F0, 2, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
